// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter sequencing IF-stage fetches and MM-stage data accesses
// Data has priority; a starvation counter forces a fetch grant after STARVE_MAX consecutive data grants.
module mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  output logic        if_stall,
  input  logic        dm_req,
  input  logic        dm_rd_wr,
  input  logic [1:0]  dm_access_size,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        dm_stall,
  output logic        mem_enable,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data_in,
  output logic [1:0]  mem_access_size,
  output logic        mem_rd_wr,
  input  logic [31:0] mem_data_out
);

  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE_IF, ISSUE_DM, WAIT} state_t;

  state_t      r_state, w_next;
  logic [3:0]  r_lat, r_starve;
  logic        r_gnt_if, r_flush;
  logic        r_mem_rd_wr;
  logic [1:0]  r_mem_size;
  logic [31:0] r_mem_addr, r_mem_data_in;
  logic [31:0] r_if_rdata, r_dm_rdata;
  logic        r_if_valid, r_dm_valid;
  logic        w_gnt_if, w_gnt_dm, w_done, w_starved, w_turn;

  // The valid-pulse cycle is a turnaround: no new grant, which also blocks double issue.
  assign w_turn    = r_if_valid | r_dm_valid;
  assign w_starved = (r_starve == 4'(STARVE_MAX));

  always_comb begin
    w_next   = r_state;
    w_gnt_if = 1'b0;
    w_gnt_dm = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_turn) begin
          if (dm_req && !(w_starved && if_req)) begin
            w_gnt_dm = 1'b1;
            w_next   = ISSUE_DM;
          end else if (if_req) begin
            w_gnt_if = 1'b1;
            w_next   = ISSUE_IF;
          end
        end
      end
      ISSUE_IF, ISSUE_DM: w_next = WAIT;
      WAIT: begin
        if (r_lat == 4'd0) begin
          w_done = 1'b1;
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= IDLE;
      r_lat         <= 4'd0;
      r_starve      <= 4'd0;
      r_gnt_if      <= 1'b0;
      r_flush       <= 1'b0;
      r_mem_rd_wr   <= 1'b1;
      r_mem_size    <= 2'b00;
      r_mem_addr    <= 32'd0;
      r_mem_data_in <= 32'd0;
      r_if_rdata    <= 32'd0;
      r_dm_rdata    <= 32'd0;
      r_if_valid    <= 1'b0;
      r_dm_valid    <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_if_valid <= 1'b0;
      r_dm_valid <= 1'b0;

      if (w_gnt_dm) begin
        r_mem_rd_wr   <= dm_rd_wr;
        r_mem_size    <= dm_access_size;
        r_mem_addr    <= dm_addr;
        r_mem_data_in <= dm_wdata;
        r_gnt_if      <= 1'b0;
        r_flush       <= 1'b0;
        r_lat         <= 4'(MEM_LAT);
      end else if (w_gnt_if) begin
        r_mem_rd_wr   <= 1'b1;
        r_mem_size    <= SZ_WORD;
        r_mem_addr    <= if_addr;
        r_gnt_if      <= 1'b1;
        r_flush       <= 1'b0;
        r_lat         <= 4'(MEM_LAT);
      end else if (r_state != IDLE && r_lat != 4'd0) begin
        r_lat <= r_lat - 4'd1;
      end

      if (if_flush && r_gnt_if && r_state != IDLE)
        r_flush <= 1'b1;

      // A flushed fetch still occupies memory but never reaches the pipeline.
      if (w_done) begin
        if (r_gnt_if) begin
          if (!(r_flush || if_flush)) begin
            r_if_rdata <= mem_data_out;
            r_if_valid <= 1'b1;
          end
        end else begin
          if (r_mem_rd_wr)
            r_dm_rdata <= mem_data_out;
          r_dm_valid <= 1'b1;
        end
      end

      if (!if_req || w_gnt_if)
        r_starve <= 4'd0;
      else if (w_gnt_dm && r_starve != 4'hF)
        r_starve <= r_starve + 4'd1;
    end
  end

  assign mem_enable      = (r_state == ISSUE_IF) || (r_state == ISSUE_DM);
  assign mem_addr        = r_mem_addr;
  assign mem_data_in     = r_mem_data_in;
  assign mem_access_size = r_mem_size;
  assign mem_rd_wr       = r_mem_rd_wr;
  assign if_rdata        = r_if_rdata;
  assign if_valid        = r_if_valid;
  assign dm_rdata        = r_dm_rdata;
  assign dm_valid        = r_dm_valid;
  assign if_stall        = if_req & ~r_if_valid;
  assign dm_stall        = dm_req & ~r_dm_valid;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with a fixed-latency memory model
module tb_mem_arbiter;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [31:0] JUNK = 32'hDEADBEEF;

  logic clk = 1'b0;
  logic reset;
  logic if_req, if_flush, if_valid, if_stall;
  logic [31:0] if_addr, if_rdata;
  logic dm_req, dm_rd_wr, dm_valid, dm_stall;
  logic [1:0] dm_access_size;
  logic [31:0] dm_addr, dm_wdata, dm_rdata;
  logic mem_enable, mem_rd_wr;
  logic [31:0] mem_addr, mem_data_in;
  logic [1:0] mem_access_size;
  logic [31:0] mem_data_out = JUNK;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] if_q[$];
  logic [31:0] dm_q[$];
  logic [31:0] gnt_q[$];
  logic [31:0] last_if = 32'd0;
  logic [31:0] last_dm = 32'd0;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_valid(if_valid), .if_stall(if_stall),
    .dm_req(dm_req), .dm_rd_wr(dm_rd_wr), .dm_access_size(dm_access_size),
    .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
    .dm_valid(dm_valid), .dm_stall(dm_stall),
    .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
    .mem_access_size(mem_access_size), .mem_rd_wr(mem_rd_wr),
    .mem_data_out(mem_data_out)
  );

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    if (a == 32'h00000010) return 32'h24020005;
    return a ^ 32'h3C1D5A0F;
  endfunction

  // Memory: data valid only in the cycle MEM_LAT after the enable cycle.
  int   m_k = 0;
  logic m_armed = 1'b0;
  logic [31:0] m_addr = 32'd0;
  always @(negedge clk) begin
    if (mem_enable) begin
      m_addr = mem_addr; m_k = MEM_LAT; m_armed = 1'b1; mem_data_out = JUNK;
    end else if (m_armed) begin
      m_k = m_k - 1;
      if (m_k == 0) begin mem_data_out = mem_f(m_addr); m_armed = 1'b0; end
      else mem_data_out = JUNK;
    end else mem_data_out = JUNK;
  end

  task automatic test_reset();
    reset = 1'b0;
    if_req = 0; if_flush = 0; if_addr = 0;
    dm_req = 0; dm_rd_wr = 1; dm_access_size = SZ_WORD; dm_addr = 0; dm_wdata = 0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++; if (mem_enable !== 1'b0) begin n_bad++; $display("FAIL reset_mem_enable: got %b want 0", mem_enable); end
    n_cmp++; if (mem_rd_wr !== 1'b1) begin n_bad++; $display("FAIL reset_mem_rd_wr: got %b want 1", mem_rd_wr); end
    n_cmp++; if (mem_addr !== 32'd0) begin n_bad++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_cmp++; if (if_valid !== 1'b0 || dm_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valids: got %b%b want 00", if_valid, dm_valid); end
    n_cmp++; if (if_rdata !== 32'd0 || dm_rdata !== 32'd0) begin n_bad++; $display("FAIL reset_rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_single_fetch();
    logic [31:0] e;
    @(negedge clk);
    if_req = 1; if_addr = 32'h00000010; if_q.push_back(mem_f(32'h00000010));
    #1;
    for (int c = 0; c < 7; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_cmp++; if (mem_enable !== (c == 1)) begin n_bad++; $display("FAIL fetch_mem_enable c%0d: got %b want %b", c, mem_enable, (c == 1)); end
      n_cmp++; if (if_stall !== (c <= 3)) begin n_bad++; $display("FAIL fetch_if_stall c%0d: got %b want %b", c, if_stall, (c <= 3)); end
      n_cmp++; if (if_valid !== (c == 4)) begin n_bad++; $display("FAIL fetch_if_valid c%0d: got %b want %b", c, if_valid, (c == 4)); end
      if (if_valid === 1'b1) begin
        if (if_q.size() == 0) begin n_bad++; $display("FAIL fetch_unexpected_valid c%0d: got valid want none", c); end
        else begin
          e = if_q.pop_front(); last_if = e;
          n_cmp++; if (if_rdata !== e) begin n_bad++; $display("FAIL fetch_rdata: got %h want %h", if_rdata, e); end
        end
        if_req = 0;
      end
    end
    n_cmp++; if (if_q.size() != 0) begin n_bad++; $display("FAIL fetch_pending: got %0d outstanding want 0", if_q.size()); if_q.delete(); if_req = 0; end
  endtask

  task automatic test_collision();
    logic [31:0] e;
    @(negedge clk);
    if_req = 1; if_addr = 32'h00000020; if_q.push_back(mem_f(32'h00000020));
    dm_req = 1; dm_rd_wr = 1; dm_access_size = SZ_WORD; dm_addr = 32'h80000100; dm_wdata = 0;
    dm_q.push_back(mem_f(32'h80000100));
    #1;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_cmp++; if (mem_enable !== (c == 1 || c == 6)) begin n_bad++; $display("FAIL coll_mem_enable c%0d: got %b want %b", c, mem_enable, (c == 1 || c == 6)); end
      if (c == 1) begin
        n_cmp++; if (mem_addr !== 32'h80000100 || mem_rd_wr !== 1'b1) begin n_bad++; $display("FAIL coll_dm_issue: got %h/%b want 80000100/1", mem_addr, mem_rd_wr); end
      end
      if (c == 6) begin
        n_cmp++; if (mem_addr !== 32'h00000020 || mem_access_size !== SZ_WORD) begin n_bad++; $display("FAIL coll_if_issue: got %h/%b want 00000020/%b", mem_addr, mem_access_size, SZ_WORD); end
      end
      n_cmp++; if (dm_stall !== (c <= 3)) begin n_bad++; $display("FAIL coll_dm_stall c%0d: got %b want %b", c, dm_stall, (c <= 3)); end
      n_cmp++; if (dm_valid !== (c == 4)) begin n_bad++; $display("FAIL coll_dm_valid c%0d: got %b want %b", c, dm_valid, (c == 4)); end
      n_cmp++; if (if_valid !== (c == 9)) begin n_bad++; $display("FAIL coll_if_valid c%0d: got %b want %b", c, if_valid, (c == 9)); end
      if (dm_valid === 1'b1 && dm_q.size() != 0) begin
        e = dm_q.pop_front(); last_dm = e;
        n_cmp++; if (dm_rdata !== e) begin n_bad++; $display("FAIL coll_dm_rdata: got %h want %h", dm_rdata, e); end
        dm_req = 0;
      end
      if (if_valid === 1'b1 && if_q.size() != 0) begin
        e = if_q.pop_front(); last_if = e;
        n_cmp++; if (if_rdata !== e) begin n_bad++; $display("FAIL coll_if_rdata: got %h want %h", if_rdata, e); end
        if_req = 0;
      end
    end
    n_cmp++; if (if_q.size() + dm_q.size() != 0) begin n_bad++; $display("FAIL coll_pending: got %0d outstanding want 0", if_q.size() + dm_q.size()); if_q.delete(); dm_q.delete(); if_req = 0; dm_req = 0; end
  endtask

  task automatic test_starvation();
    logic [31:0] e;
    int ndm = 0;
    int budget = 80;
    @(negedge clk);
    for (int k = 0; k < 4; k++) gnt_q.push_back(32'h80000200 + 32'(4 * k));
    gnt_q.push_back(32'h00000040);
    gnt_q.push_back(32'h80000210);
    if_req = 1; if_addr = 32'h00000040; if_q.push_back(mem_f(32'h00000040));
    dm_req = 1; dm_rd_wr = 1; dm_access_size = SZ_WORD; dm_addr = 32'h80000200;
    dm_q.push_back(mem_f(32'h80000200));
    #1;
    while ((dm_req || if_req) && budget > 0) begin
      if (mem_enable === 1'b1) begin
        if (gnt_q.size() == 0) begin n_bad++; $display("FAIL starve_extra_grant: got %h want none", mem_addr); end
        else begin
          e = gnt_q.pop_front();
          n_cmp++; if (mem_addr !== e) begin n_bad++; $display("FAIL starve_grant_order: got %h want %h", mem_addr, e); end
        end
      end
      if (dm_valid === 1'b1 && dm_q.size() != 0) begin
        e = dm_q.pop_front(); last_dm = e;
        n_cmp++; if (dm_rdata !== e) begin n_bad++; $display("FAIL starve_dm_rdata: got %h want %h", dm_rdata, e); end
        ndm++;
        if (ndm < 5) begin
          dm_addr = 32'h80000200 + 32'(4 * ndm);
          dm_q.push_back(mem_f(dm_addr));
        end else dm_req = 0;
      end
      if (if_valid === 1'b1 && if_q.size() != 0) begin
        e = if_q.pop_front(); last_if = e;
        n_cmp++; if (if_rdata !== e) begin n_bad++; $display("FAIL starve_if_rdata: got %h want %h", if_rdata, e); end
        if_req = 0;
      end
      @(negedge clk); #1;
      budget--;
    end
    n_cmp++; if (budget == 0 || gnt_q.size() != 0) begin n_bad++; $display("FAIL starve_timeout: got %0d grants left want 0", gnt_q.size()); end
    gnt_q.delete(); if_q.delete(); dm_q.delete(); if_req = 0; dm_req = 0;
  endtask

  task automatic test_store_byte();
    logic [31:0] e;
    @(negedge clk);
    dm_req = 1; dm_rd_wr = 0; dm_access_size = SZ_BYTE; dm_addr = 32'h80000003; dm_wdata = 32'h000000AB;
    dm_q.push_back(last_dm);
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_cmp++; if (mem_enable !== (c == 1)) begin n_bad++; $display("FAIL store_mem_enable c%0d: got %b want %b", c, mem_enable, (c == 1)); end
      if (c >= 1 && c <= 3) begin
        n_cmp++;
        if (mem_rd_wr !== 1'b0 || mem_access_size !== SZ_BYTE || mem_addr !== 32'h80000003 || mem_data_in !== 32'h000000AB) begin
          n_bad++; $display("FAIL store_port c%0d: got %b/%b/%h/%h want 0/%b/80000003/000000ab", c, mem_rd_wr, mem_access_size, mem_addr, mem_data_in, SZ_BYTE);
        end
      end
      n_cmp++; if (dm_valid !== (c == 4)) begin n_bad++; $display("FAIL store_dm_valid c%0d: got %b want %b", c, dm_valid, (c == 4)); end
      if (dm_valid === 1'b1 && dm_q.size() != 0) begin
        e = dm_q.pop_front();
        n_cmp++; if (dm_rdata !== e) begin n_bad++; $display("FAIL store_dm_rdata: got %h want %h", dm_rdata, e); end
        dm_req = 0;
      end
    end
    n_cmp++; if (dm_q.size() != 0) begin n_bad++; $display("FAIL store_pending: got %0d want 0", dm_q.size()); dm_q.delete(); dm_req = 0; end
    dm_rd_wr = 1; dm_access_size = SZ_WORD;
  endtask

  task automatic test_flush();
    logic [31:0] e;
    @(negedge clk);
    if_req = 1; if_addr = 32'h00000100; if_q.push_back(mem_f(32'h00000100));
    #1;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_cmp++; if (mem_enable !== (c == 1 || c == 5)) begin n_bad++; $display("FAIL flush_mem_enable c%0d: got %b want %b", c, mem_enable, (c == 1 || c == 5)); end
      n_cmp++; if (if_valid !== (c == 8)) begin n_bad++; $display("FAIL flush_if_valid c%0d: got %b want %b", c, if_valid, (c == 8)); end
      if (c == 4) begin
        n_cmp++; if (if_rdata !== last_if) begin n_bad++; $display("FAIL flush_rdata_hold: got %h want %h", if_rdata, last_if); end
      end
      if (c == 5) begin
        n_cmp++; if (mem_addr !== 32'h00000104) begin n_bad++; $display("FAIL flush_refetch_addr: got %h want 00000104", mem_addr); end
      end
      if (if_valid === 1'b1 && if_q.size() != 0) begin
        e = if_q.pop_front(); last_if = e;
        n_cmp++; if (if_rdata !== e) begin n_bad++; $display("FAIL flush_if_rdata: got %h want %h", if_rdata, e); end
        if_req = 0;
      end
      if (c == 2) begin
        if_flush = 1;
        void'(if_q.pop_back());
      end
      if (c == 3) begin
        if_flush = 0; if_addr = 32'h00000104; if_q.push_back(mem_f(32'h00000104));
      end
    end
    n_cmp++; if (if_q.size() != 0) begin n_bad++; $display("FAIL flush_pending: got %0d want 0", if_q.size()); if_q.delete(); if_req = 0; end
  endtask

  task automatic test_async_reset();
    logic [31:0] e;
    @(negedge clk);
    if_req = 1; if_addr = 32'h00000200; if_q.push_back(mem_f(32'h00000200));
    repeat (2) @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    n_cmp++; if (mem_enable !== 1'b0 || mem_rd_wr !== 1'b1) begin n_bad++; $display("FAIL areset_mem_ctl: got %b/%b want 0/1", mem_enable, mem_rd_wr); end
    n_cmp++; if (mem_addr !== 32'd0 || mem_data_in !== 32'd0 || mem_access_size !== 2'b00) begin n_bad++; $display("FAIL areset_mem_port: got %h/%h/%b want 0/0/00", mem_addr, mem_data_in, mem_access_size); end
    n_cmp++; if (if_rdata !== 32'd0 || dm_rdata !== 32'd0) begin n_bad++; $display("FAIL areset_rdata: got %h/%h want 0/0", if_rdata, dm_rdata); end
    if_q.delete(); if_req = 0; last_if = 32'd0; last_dm = 32'd0;
    @(negedge clk);
    n_cmp++; if (if_valid !== 1'b0) begin n_bad++; $display("FAIL areset_abandon: got %b want 0", if_valid); end
    reset = 1'b1;
    if_req = 1; if_addr = 32'h00000300; if_q.push_back(mem_f(32'h00000300));
    #1;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      n_cmp++; if (mem_enable !== (c == 1)) begin n_bad++; $display("FAIL areset_mem_enable c%0d: got %b want %b", c, mem_enable, (c == 1)); end
      n_cmp++; if (if_valid !== (c == 4)) begin n_bad++; $display("FAIL areset_if_valid c%0d: got %b want %b", c, if_valid, (c == 4)); end
      if (if_valid === 1'b1 && if_q.size() != 0) begin
        e = if_q.pop_front(); last_if = e;
        n_cmp++; if (if_rdata !== e) begin n_bad++; $display("FAIL areset_if_rdata: got %h want %h", if_rdata, e); end
        if_req = 0;
      end
    end
    n_cmp++; if (if_q.size() != 0) begin n_bad++; $display("FAIL areset_pending: got %0d want 0", if_q.size()); if_q.delete(); if_req = 0; end
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_collision();
    test_starvation();
    test_store_byte();
    test_flush();
    test_async_reset();
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
